hilo_muldiv: RTL and testbench
==============================

HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 Parameters: none; all widths fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request strobe, sampled at the rising edge of clk.
REQ-005 op  input  3  operation code, type muldiv_op_t, valid with start.
REQ-006 a  input  32  first operand; driven from regfile rs.
REQ-007 b  input  32  second operand; driven from regfile rt.
REQ-008 busy  output  1  high while an iterative operation is in progress.
REQ-009 done  output  1  one-cycle pulse when HI/LO take an iterative result.
REQ-010 hi  output  32  HI register, continuously readable (MFHI source).
REQ-011 lo  output  32  LO register, continuously readable (MFLO source).

Function
REQ-012 The op encodings SHALL be MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6 and 7 SHALL be ignored as no-ops.
REQ-013 The block SHALL accept a request only when start=1 and busy=0; a start while busy=1 SHALL be ignored with no effect.
REQ-014 MTHI SHALL set hi=a, and MTLO SHALL set lo=a, at the accepting edge; busy and done SHALL stay 0.
REQ-015 MULT/MULTU/DIV/DIVU SHALL latch a and b at the accepting edge, enter state RUN, and hold busy=1 for exactly 32 cycles.
REQ-016 The FSM SHALL have states IDLE, RUN and FINISH, with transitions:
  - IDLE->RUN on an accepted iterative op;
  - RUN->RUN for 31 further cycles, counted by a 5-bit counter;
  - RUN->FINISH after the 32nd iteration;
  - FINISH->IDLE unconditionally.
REQ-017 In FINISH, hi/lo SHALL be written, busy=0 and done=1; the result is therefore visible 33 cycles after the accepting edge.
REQ-018 A new start SHALL be accepted in the FINISH cycle, since busy=0 there.
REQ-019 hi/lo SHALL hold their previous values throughout RUN; intermediate values SHALL never appear on hi/lo.
REQ-020 MULTU SHALL produce the unsigned 64-bit product a*b, with {hi,lo} = product.
REQ-021 MULT SHALL produce the two's-complement 64-bit product, implemented as a magnitude multiply followed by sign correction.
REQ-022 DIVU SHALL give lo = unsigned quotient and hi = unsigned remainder, using a restoring 1-bit-per-cycle algorithm.
REQ-023 DIV SHALL be signed:
  - the quotient truncates toward zero;
  - the remainder takes the sign of the dividend;
  - the invariant a = lo*b + hi SHALL hold.
REQ-024 Divide by zero (b=0, DIV or DIVU) SHALL give lo=32'hFFFFFFFF and hi=a, complete in the normal 33 cycles, and raise no error.
REQ-025 Signed overflow (DIV 32'h80000000 by 32'hFFFFFFFF) SHALL give lo=32'h80000000 and hi=0.
REQ-026 done SHALL be combinationally equal to (state==FINISH); busy SHALL be combinationally equal to (state==RUN).

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, counter=0, hi=0, lo=0, busy=0 and done=0.
REQ-028 Reset during RUN SHALL abort the operation; no result SHALL be written after rst deasserts.
REQ-029 Requests SHALL be accepted from the first rising edge after rst deasserts.

Structure
REQ-030 The muldiv_op_t enum and the state enum SHALL reside in shared package mips_pkg, alongside other ISA constants.
REQ-031 Multiply and divide SHALL share one 64-bit shift register and one 33-bit adder/subtractor.
REQ-032 A single sub-module, muldiv_sign, SHALL handle the operand absolute-value conversion and result sign correction.
REQ-033 hi/lo SHALL be the only architectural state; the regfile write-back of MFHI/MFLO is outside this block.

Verification
REQ-034 Reset: after rst pulse -> hi=0, lo=0, busy=0, done=0; a start with MULT issued during RUN followed by rst -> no write occurs.
REQ-035 Products: MULTU a=32'hFFFFFFFF, b=2 -> hi=1, lo=32'hFFFFFFFE; MULT a=-3, b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; both with done exactly 33 cycles after the accepting edge.
REQ-036 Quotients: DIV a=-7, b=2 -> lo=-3, hi=-1; DIVU a=7, b=2 -> lo=3, hi=1; DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
REQ-037 Divide by zero: DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5, done after 33 cycles.
REQ-038 Handshake:
  - a start during busy -> ignored; hi/lo unchanged from the first result;
  - a start issued in the FINISH cycle -> accepted, busy high on the next cycle;
  - MTHI a=32'h1234 while idle -> hi=32'h1234 next cycle, done stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared ISA-level types and constants for the MIPS core: HI/LO op codes,
// the multiply/divide sequencer states and a few related function codes.
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MTHI = 6'h11;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;
    localparam logic [5:0] FUNCT_MTLO = 6'h13;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign.sv
// Operand magnitude conversion for signed ops and the matching sign
// correction applied to the raw unsigned multiply/divide result.
module muldiv_sign
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0]   a,
    input  logic [WORD_W-1:0]   b,
    input  logic                signed_op,
    output logic [WORD_W-1:0]   abs_a,
    output logic [WORD_W-1:0]   abs_b,
    output logic                neg_prod,
    output logic                neg_quot,
    output logic                neg_rem,
    input  logic                is_div,
    input  logic                fix_prod,
    input  logic                fix_quot,
    input  logic                fix_rem,
    input  logic [2*WORD_W-1:0] raw,
    output logic [WORD_W-1:0]   res_hi,
    output logic [WORD_W-1:0]   res_lo
);
    logic [2*WORD_W-1:0] prod_fix;
    logic [WORD_W-1:0]   quot_fix;
    logic [WORD_W-1:0]   rem_fix;

    assign abs_a = (signed_op && a[WORD_W-1]) ? (~a + 32'd1) : a;
    assign abs_b = (signed_op && b[WORD_W-1]) ? (~b + 32'd1) : b;

    assign neg_prod = signed_op && (a[WORD_W-1] ^ b[WORD_W-1]);
    // A zero divisor leaves the all-ones quotient untouched; the remainder
    // still takes the dividend sign so that hi comes back as the original a.
    assign neg_quot = neg_prod && (b != '0);
    assign neg_rem  = signed_op && a[WORD_W-1];

    assign prod_fix = fix_prod ? (~raw + 64'd1) : raw;
    assign quot_fix = fix_quot ? (~raw[WORD_W-1:0] + 32'd1) : raw[WORD_W-1:0];
    assign rem_fix  = fix_rem ? (~raw[2*WORD_W-1:WORD_W] + 32'd1) : raw[2*WORD_W-1:WORD_W];

    assign res_hi = is_div ? rem_fix  : prod_fix[2*WORD_W-1:WORD_W];
    assign res_lo = is_div ? quot_fix : prod_fix[WORD_W-1:0];

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO unit: MTHI/MTLO plus 32-cycle iterative multiply/divide sharing one
// 64-bit shift register and one 33-bit adder.
//
//   state     | meaning
//   ST_IDLE   | waiting for a request, hi/lo stable
//   ST_RUN    | one multiply/divide iteration per cycle, busy=1
//   ST_FINISH | sign-corrected result written to hi/lo at the next edge, done=1
module hilo_muldiv
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  muldiv_op_t        op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);
    muldiv_state_t state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [2*WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0]   opb_q, opb_d;
    logic [WORD_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                is_div_q, is_div_d;
    logic                fix_prod_q, fix_prod_d;
    logic                fix_quot_q, fix_quot_d;
    logic                fix_rem_q, fix_rem_d;

    logic                signed_op, div_op, run_w;
    logic [WORD_W-1:0]   abs_a, abs_b, res_hi, res_lo;
    logic                neg_prod, neg_quot, neg_rem;
    logic [WORD_W:0]     add_x, add_y, add_s;
    logic                add_cin, add_cout;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign div_op    = (op == OP_DIV) || (op == OP_DIVU);
    assign run_w     = (state_q == ST_RUN);
    assign busy      = run_w;
    assign done      = (state_q == ST_FINISH);
    assign hi        = hi_q;
    assign lo        = lo_q;

    muldiv_sign u_sign (
        .a         (a),
        .b         (b),
        .signed_op (signed_op),
        .abs_a     (abs_a),
        .abs_b     (abs_b),
        .neg_prod  (neg_prod),
        .neg_quot  (neg_quot),
        .neg_rem   (neg_rem),
        .is_div    (is_div_q),
        .fix_prod  (fix_prod_q),
        .fix_quot  (fix_quot_q),
        .fix_rem   (fix_rem_q),
        .raw       (acc_q),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    // Divide: trial-subtract divisor from the shifted partial remainder.
    // Multiply: add multiplicand into the upper half when the LSB is set.
    assign add_x   = is_div_q ? acc_q[2*WORD_W-1:WORD_W-1] : {1'b0, acc_q[2*WORD_W-1:WORD_W]};
    assign add_y   = is_div_q ? ~{1'b0, opb_q} : {1'b0, opb_q};
    assign add_cin = is_div_q;
    assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {33'd0, add_cin};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        fix_prod_d = fix_prod_q;
        fix_quot_d = fix_quot_q;
        fix_rem_d  = fix_rem_q;

        case (state_q)
            ST_RUN: begin
                if (is_div_q) begin
                    acc_d = add_cout ? {add_s[WORD_W-1:0], acc_q[WORD_W-2:0], 1'b1}
                                     : {acc_q[2*WORD_W-2:0], 1'b0};
                end else begin
                    acc_d = acc_q[0] ? {add_s, acc_q[WORD_W-1:1]}
                                     : {1'b0, acc_q[2*WORD_W-1:1]};
                end
                if (cnt_q == 5'd0) begin
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_FINISH: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = ST_IDLE;
            end
            default: ;
        endcase

        // A move issued in the FINISH cycle is younger than the result, so it wins.
        if (start && !run_w) begin
            case (op)
                OP_MTHI: hi_d = a;
                OP_MTLO: lo_d = a;
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    state_d    = ST_RUN;
                    cnt_d      = 5'd31;
                    acc_d      = {32'd0, abs_a};
                    opb_d      = abs_b;
                    is_div_d   = div_op;
                    fix_prod_d = neg_prod;
                    fix_quot_d = neg_quot;
                    fix_rem_d  = neg_rem;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            acc_q      <= '0;
            opb_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            fix_prod_q <= 1'b0;
            fix_quot_q <= 1'b0;
            fix_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            fix_prod_q <= fix_prod_d;
            fix_quot_q <= fix_quot_d;
            fix_rem_q  <= fix_rem_d;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: vector table for iterative ops plus
// hand-written reset, move, no-op and handshake sequences.
module tb_hilo_muldiv;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    muldiv_op_t  op_i;
    logic [31:0] a_i, b_i;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    hilo_muldiv dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op_i),
        .a     (a_i),
        .b     (b_i),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input muldiv_op_t o, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1;
        op_i  = o;
        a_i   = av;
        b_i   = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // busy after edges 0..31, done after edge 32 only, hi/lo updated at edge 33.
    task automatic run_iter(input int idx, input vec_t v);
        logic [31:0] h0, l0;
        bit busy_ok, hold_ok;
        int done_at;
        string nm;
        nm      = $sformatf("vec%0d", idx);
        h0      = hi;
        l0      = lo;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        done_at = -1;
        issue(v.op, v.a, v.b);
        for (int k = 0; k <= 33; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k <= 31 && busy !== 1'b1) busy_ok = 1'b0;
            if (k >= 32 && busy !== 1'b0) busy_ok = 1'b0;
            if (done === 1'b1) done_at = (done_at < 0) ? k : 99;
            if (k <= 32 && (hi !== h0 || lo !== l0)) hold_ok = 1'b0;
        end
        check({nm, "_done_edge"}, done_at, 32);
        check({nm, "_busy_window"}, {31'd0, busy_ok}, 32'd1);
        check({nm, "_hilo_hold"}, {31'd0, hold_ok}, 32'd1);
        check({nm, "_hi"}, hi, v.eh);
        check({nm, "_lo"}, lo, v.el);
    endtask

    initial begin
        bit wrote;

        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{OP_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{OP_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF};
        vecs[6] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[7] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[9] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        rst   = 1'b1;
        start = 1'b0;
        op_i  = OP_MULT;
        a_i   = '0;
        b_i   = '0;
        #2;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(OP_MTHI, 32'h00001234, 32'd0);
        check("mthi_hi", hi, 32'h00001234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_done", {31'd0, done}, 32'd0);
        issue(OP_MTLO, 32'h0000ABCD, 32'd0);
        check("mtlo_lo", lo, 32'h0000ABCD);
        check("mtlo_hi_kept", hi, 32'h00001234);

        issue(muldiv_op_t'(3'd6), 32'h11111111, 32'd3);
        check("nop6_busy", {31'd0, busy}, 32'd0);
        check("nop6_hi", hi, 32'h00001234);
        issue(muldiv_op_t'(3'd7), 32'h22222222, 32'd3);
        check("nop7_lo", lo, 32'h0000ABCD);
        @(posedge clk);
        #1;
        check("nop7_busy_later", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 10; i++) run_iter(i, vecs[i]);

        // Starts while busy must be dropped.
        issue(OP_MULTU, 32'd3, 32'd5);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op_i  = OP_MTHI;
        a_i   = 32'hDEADBEEF;
        @(negedge clk);
        op_i  = OP_DIVU;
        b_i   = 32'd1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 && done !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        check("ign_done_seen", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        check("ign_hi", hi, 32'd0);
        check("ign_lo", lo, 32'd15);
        check("ign_busy", {31'd0, busy}, 32'd0);

        // Start in the FINISH cycle is accepted.
        issue(OP_DIVU, 32'd7, 32'd2);
        for (int k = 0; k < 40 && done !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        check("fin_done_seen", {31'd0, done}, 32'd1);
        start = 1'b1;
        op_i  = OP_MULTU;
        a_i   = 32'd2;
        b_i   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("fin_busy_next", {31'd0, busy}, 32'd1);
        check("fin_first_hi", hi, 32'd1);
        check("fin_first_lo", lo, 32'd3);
        for (int k = 0; k < 40 && done !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("fin_second_hi", hi, 32'd0);
        check("fin_second_lo", lo, 32'd6);

        // Reset mid-operation aborts with no later write.
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wrote = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) wrote = 1'b1;
        end
        check("arst_no_write", {31'd0, wrote}, 32'd0);

        // Accept on the first edge after reset release.
        #3;
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        op_i  = OP_MTLO;
        a_i   = 32'h00000077;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("post_rst_accept", lo, 32'h00000077);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
